// File: rtl/freq_sweep_ctl.sv
// Frequency sweep controller: steps the DDS frequency word from a start point to a
// stop point in fixed increments, holding each point for a programmable dwell.
// Supports single, repeating sawtooth and triangle sweeps, with pause and abort.
module freq_sweep_ctl #(
  parameter int              FW       = 12,
  parameter int              DWELL_W  = 16,
  parameter logic [FW-1:0]   RST_FREQ = FW'(1)
) (
  input  logic               clk_10khz,
  input  logic               rst,
  input  logic [FW-1:0]      cfg_start,
  input  logic [FW-1:0]      cfg_stop,
  input  logic [FW-1:0]      cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic               start,
  input  logic               pause,
  input  logic               abort,
  output logic [FW-1:0]      freq_ctl,
  output logic               freq_upd,
  output logic               busy,
  output logic               done,
  output logic               dir,
  output logic [7:0]         sweep_cnt
);

  // Encoding keeps busy and done as single state bits so their decode cannot glitch.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t               state, state_nxt;

  logic [FW-1:0]        start_l;
  logic [FW-1:0]        stop_l;
  logic [FW-1:0]        step_l;
  logic [DWELL_W-1:0]   dwell_m1;
  logic [1:0]           mode_l;
  logic [FW-1:0]        tgt;
  logic [DWELL_W-1:0]   cnt;

  logic                 accept;
  logic                 tick;
  logic                 at_tgt;
  logic                 single;
  logic                 advance;
  logic                 wrap;
  logic                 turn;
  logic                 finish;
  logic [FW-1:0]        other_end;
  logic [FW-1:0]        step_in;
  logic [DWELL_W-1:0]   dwell_m1_in;

  // One step of magnitude stp from cur toward tgt_v, computed one bit wider so that
  // overshooting the target or wrapping past either end of the word clamps to tgt_v.
  function automatic logic [FW-1:0] step_toward(input logic [FW-1:0] cur,
                                                input logic [FW-1:0] tgt_v,
                                                input logic [FW-1:0] stp,
                                                input logic          up);
    logic [FW:0] nxt;
    if (up) begin
      nxt = {1'b0, cur} + {1'b0, stp};
      if (nxt[FW] || (nxt[FW-1:0] > tgt_v)) nxt = {1'b0, tgt_v};
    end else begin
      nxt = {1'b0, cur} - {1'b0, stp};
      if (nxt[FW] || (nxt[FW-1:0] < tgt_v)) nxt = {1'b0, tgt_v};
    end
    return nxt[FW-1:0];
  endfunction

  // Zero step and zero dwell both behave as one.
  assign step_in     = (cfg_step == '0) ? FW'(1) : cfg_step;
  assign dwell_m1_in = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);

  assign accept    = (state == IDLE) && start && !abort;
  assign tick      = (state == RUN) && !abort && !pause && (cnt == '0);
  assign at_tgt    = (freq_ctl == tgt);
  assign single    = (mode_l[0] == mode_l[1]);
  assign advance   = tick && !at_tgt;
  assign wrap      = tick && at_tgt && (mode_l == 2'd1);
  assign turn      = tick && at_tgt && (mode_l == 2'd2);
  assign finish    = tick && at_tgt && single;
  assign other_end = (tgt == stop_l) ? start_l : stop_l;

  // State register.
  always_ff @(posedge clk_10khz or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort wins over everything else.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN: begin
        if (abort)       state_nxt = IDLE;
        else if (finish) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Sweep configuration captured on an accepted start; target swaps at triangle turns.
  always_ff @(posedge clk_10khz) begin
    if (accept) begin
      start_l  <= cfg_start;
      stop_l   <= cfg_stop;
      step_l   <= step_in;
      dwell_m1 <= dwell_m1_in;
      mode_l   <= cfg_mode;
      tgt      <= cfg_stop;
    end else if (turn) begin
      tgt      <= other_end;
    end
  end

  // Dwell counter: frozen while paused, reloads whenever a point's dwell elapses.
  always_ff @(posedge clk_10khz) begin
    if (accept)
      cnt <= dwell_m1_in;
    else if ((state == RUN) && !abort && !pause)
      cnt <= (cnt == '0) ? dwell_m1 : cnt - DWELL_W'(1);
  end

  // Frequency word, update strobe, direction and completed-sweep count.
  always_ff @(posedge clk_10khz or posedge rst) begin
    if (rst) begin
      freq_ctl  <= RST_FREQ;
      freq_upd  <= 1'b0;
      dir       <= 1'b0;
      sweep_cnt <= 8'd0;
    end else begin
      freq_upd <= accept | advance | wrap | turn;
      if (accept)       freq_ctl <= cfg_start;
      else if (advance) freq_ctl <= step_toward(freq_ctl, tgt, step_l, dir);
      else if (wrap)    freq_ctl <= start_l;
      else if (turn)    freq_ctl <= step_toward(freq_ctl, other_end, step_l, ~dir);
      if (accept)       dir <= (cfg_stop >= cfg_start);
      else if (turn)    dir <= ~dir;
      if (finish || wrap || (turn && (freq_ctl == start_l)))
        sweep_cnt <= sweep_cnt + 8'd1;
    end
  end

endmodule
